// File: rtl/sha_multiround_stage_if.sv
// Beat bus between SHA-256 round stages: working state, 16-word message window, sideband tag, valid/ready handshake.
// Ports: state (a..h, state[0]=a), w (w[0]=oldest word), newblock tag, valid (producer->consumer), ready (consumer->producer).
// master drives the beat and samples ready; slave samples the beat and drives ready.
interface sha_multiround_stage_if;
  logic [7:0][31:0]  state;
  logic [15:0][31:0] w;
  logic              valid;
  logic              newblock;
  logic              ready;

  modport master (output state, output w, output valid, output newblock, input ready);
  modport slave  (input state, input w, input valid, input newblock, output ready);
endinterface

// File: rtl/sha_multiround_stage.sv
// SHA-256 pipeline stage applying ROUNDS compression rounds and advancing the message window (expand or rotate).
// Latency: 1 cycle from input acceptance to valid on dn; single output register, rounds chained combinationally.
// Backpressure: up.ready = !valid || dn.ready (no skid buffer); outputs are bit-stable while dn stalls.
// Ports: clk, rst (synchronous, active high); up = incoming beat (slave), dn = outgoing beat (master).
module sha_multiround_stage #(
  parameter int ROUNDS      = 1,
  parameter int FIRST_ROUND = 0,
  parameter bit EXPAND      = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  sha_multiround_stage_if.slave         up,
  sha_multiround_stage_if.master        dn
);

  typedef logic [7:0][31:0]  hash_state_t;
  typedef logic [15:0][31:0] window_t;

  if (!(ROUNDS == 1 || ROUNDS == 2 || ROUNDS == 4) || FIRST_ROUND < 0 || FIRST_ROUND > 64 - ROUNDS) begin : g_bad_param
    $error("sha_multiround_stage: illegal ROUNDS=%0d / FIRST_ROUND=%0d", ROUNDS, FIRST_ROUND);
  end

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One compression round; state index 0 is a, index 7 is h.
  function automatic hash_state_t sha_round(input hash_state_t s, input logic [31:0] k, input logic [31:0] wd);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = s[7] + big_sigma1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + wd;
    t2 = big_sigma0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    return {s[6], s[5], s[4], s[3] + t1, s[2], s[1], s[0], t1 + t2};
  endfunction

  function automatic hash_state_t run_rounds(input hash_state_t s_in, input window_t win);
    hash_state_t s;
    s = s_in;
    for (int j = 0; j < 4; j++) begin
      if (j < ROUNDS) s = sha_round(s, K_TAB[6'(FIRST_ROUND + j)], win[4'(j)]);
    end
    return s;
  endfunction

  // x holds the window followed by up to four new schedule words. Later new
  // words read earlier ones (t-2), so ROUNDS=4 chains two expansions deep.
  // Words beyond ROUNDS are computed but never selected.
  function automatic window_t next_window(input window_t win);
    logic [31:0] x [20];
    window_t     r;
    for (int t = 0; t < 16; t++) x[5'(t)] = win[4'(t)];
    for (int t = 16; t < 20; t++) begin
      x[5'(t)] = small_sigma1(x[5'(t - 2)]) + x[5'(t - 7)] + small_sigma0(x[5'(t - 15)]) + x[5'(t - 16)];
    end
    for (int i = 0; i < 16; i++) begin
      if (EXPAND) r[4'(i)] = x[5'(i + ROUNDS)];
      else        r[4'(i)] = win[4'(i + ROUNDS)];
    end
    return r;
  endfunction

  hash_state_t state_q;
  window_t     w_q;
  logic        valid_q;
  logic        newblock_q;
  logic        accept;

  assign up.ready = !valid_q || dn.ready;
  assign accept   = up.valid && up.ready;

  // Data registers change only on acceptance; a drained beat leaves its data in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      newblock_q <= 1'b0;
      state_q    <= '0;
      w_q        <= '0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      newblock_q <= up.newblock;
      state_q    <= run_rounds(up.state, up.w);
      w_q        <= next_window(up.w);
    end else if (dn.ready) begin
      valid_q    <= 1'b0;
    end
  end

  assign dn.valid    = valid_q;
  assign dn.newblock = newblock_q;
  assign dn.state    = state_q;
  assign dn.w        = w_q;

endmodule

// File: tb/tb_sha_multiround_stage.sv
module tb_sha_multiround_stage;

  typedef logic [7:0][31:0]  st_t;
  typedef logic [15:0][31:0] win_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  sha_multiround_stage_if u1 ();
  sha_multiround_stage_if d1 ();
  sha_multiround_stage_if u2 ();
  sha_multiround_stage_if d2 ();
  sha_multiround_stage_if u4 ();
  sha_multiround_stage_if d4 ();
  sha_multiround_stage_if ch [17] ();

  sha_multiround_stage #(.ROUNDS(1), .FIRST_ROUND(0), .EXPAND(1'b1)) dut_r1 (.clk(clk), .rst(rst), .up(u1), .dn(d1));
  sha_multiround_stage #(.ROUNDS(2), .FIRST_ROUND(0), .EXPAND(1'b1)) dut_r2 (.clk(clk), .rst(rst), .up(u2), .dn(d2));
  sha_multiround_stage #(.ROUNDS(4), .FIRST_ROUND(8), .EXPAND(1'b1)) dut_r4 (.clk(clk), .rst(rst), .up(u4), .dn(d4));

  for (genvar g = 0; g < 16; g++) begin : g_chain
    sha_multiround_stage #(.ROUNDS(4), .FIRST_ROUND(4 * g), .EXPAND(1'b0)) stg (.clk(clk), .rst(rst), .up(ch[g]), .dn(ch[g + 1]));
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Plain textbook rounds; the word for global round r is w[r mod 16] of the original window.
  function automatic st_t ref_rounds(input st_t s, input win_t w, input int first, input int n);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {h, g, f, e, d, c, b, a} = s;
    for (int r = 0; r < n; r++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K[first + r] + w[r % 16];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h, g, f, e, d, c, b, a};
  endfunction

  function automatic win_t ref_window(input win_t w, input int n, input bit expand);
    logic [31:0] sch [20];
    win_t o;
    for (int t = 0; t < 16; t++) sch[t] = w[t];
    for (int t = 16; t < 20; t++)
      sch[t] = (rr(sch[t-2], 17) ^ rr(sch[t-2], 19) ^ (sch[t-2] >> 10)) + sch[t-7]
             + (rr(sch[t-15], 7) ^ rr(sch[t-15], 18) ^ (sch[t-15] >> 3)) + sch[t-16];
    for (int i = 0; i < 16; i++) o[i] = expand ? sch[i + n] : w[(i + n) % 16];
    return o;
  endfunction

  function automatic st_t rand_st();
    st_t s;
    for (int i = 0; i < 8; i++) s[i] = $urandom;
    return s;
  endfunction

  function automatic win_t rand_win();
    win_t w;
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- cycle model for the ROUNDS=4 expanding stage ----------------
  bit   m_valid = 1'b0;
  bit   m_nb    = 1'b0;
  st_t  m_st    = '0;
  win_t m_w     = '0;
  st_t  cur_st;
  win_t cur_w;
  int   n_acc, dut_out;

  task automatic a4_cycle(input bit vi, input bit nb, input bit rdy);
    bit exp_rdy, acc;
    u4.valid = vi; u4.newblock = nb; u4.state = cur_st; u4.w = cur_w; d4.ready = rdy;
    #1;
    exp_rdy = !m_valid || rdy;
    chk("ready_o", u4.ready, exp_rdy);
    if (d4.valid && rdy) dut_out++;
    acc = vi && exp_rdy;
    if (acc) begin
      m_valid = 1'b1; m_nb = nb;
      m_st = ref_rounds(cur_st, cur_w, 8, 4);
      m_w  = ref_window(cur_w, 4, 1'b1);
      n_acc++;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("r4_valid", d4.valid, m_valid);
    chk("r4_newblock", d4.newblock, m_nb);
    chk("r4_state", d4.state, m_st);
    chk("r4_window", d4.w, m_w);
    if (acc) begin cur_st = rand_st(); cur_w = rand_win(); end
  endtask

  // ---------------- directed sequence ----------------
  localparam st_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  win_t abc;
  win_t cw;
  st_t  cs;
  int   cycles, iters;

  initial begin
    abc = '0; abc[0] = 32'h61626380; abc[15] = 32'h00000018;
    u1.valid = 0; u1.newblock = 0; u1.state = '0; u1.w = '0; d1.ready = 1;
    u2.valid = 0; u2.newblock = 0; u2.state = '0; u2.w = '0; d2.ready = 1;
    u4.valid = 0; u4.newblock = 0; u4.state = '0; u4.w = '0; d4.ready = 1;
    ch[0].valid = 0; ch[0].newblock = 0; ch[0].state = '0; ch[0].w = '0; ch[16].ready = 1;
    cur_st = rand_st(); cur_w = rand_win();

    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_valid", d1.valid, 1'b0);
    chk("rst_newblock", d1.newblock, 1'b0);
    chk("rst_state", d1.state, '0);
    chk("rst_window", d1.w, '0);
    chk("rst_ready", u1.ready, 1'b1);

    // "abc" block through 1- and 2-round stages
    u1.state = IV; u1.w = abc; u1.valid = 1; u1.newblock = 1;
    u2.state = IV; u2.w = abc; u2.valid = 1; u2.newblock = 0;
    @(posedge clk); #1;
    u1.valid = 0; u2.valid = 0;
    chk("r1_valid", d1.valid, 1'b1);
    chk("r1_newblock", d1.newblock, 1'b1);
    chk("r1_a", d1.state[0], 32'h5D6AEBCD);
    chk("r1_e", d1.state[4], 32'hFA2A4622);
    chk("r1_h", d1.state[7], 32'h1F83D9AB);
    chk("r1_w15", d1.w[15], 32'h61626380);
    chk("r1_state_model", d1.state, ref_rounds(IV, abc, 0, 1));
    chk("r1_window_model", d1.w, ref_window(abc, 1, 1'b1));
    chk("r2_a", d2.state[0], 32'h5A6AD9AD);
    chk("r2_e", d2.state[4], 32'h78CE7989);
    chk("r2_w14", d2.w[14], 32'h61626380);
    chk("r2_w15", d2.w[15], 32'h000F0000);
    chk("r2_state_model", d2.state, ref_rounds(IV, abc, 0, 2));
    chk("r2_window_model", d2.w, ref_window(abc, 2, 1'b1));

    // 16-stage rotating chain: 64 rounds, window returns to the original block
    for (int i = 0; i < 16; i++) cw[i] = i;
    cs = rand_st();
    ch[0].state = cs; ch[0].w = cw; ch[0].valid = 1; ch[0].newblock = 1;
    @(posedge clk); #1;
    ch[0].valid = 0;
    cycles = 1;
    for (int i = 0; i < 16; i++) chk("chain_s0_w", ch[1].w[i], 32'((i + 4) % 16));
    while (!ch[16].valid && cycles < 40) begin @(posedge clk); #1; cycles++; end
    chk("chain_latency", cycles, 16);
    chk("chain_window", ch[16].w, cw);
    chk("chain_state", ch[16].state, ref_rounds(cs, cw, 0, 64));
    chk("chain_newblock", ch[16].newblock, 1'b1);

    // random backpressure: 8 beats, random valid and ready
    n_acc = 0; dut_out = 0; iters = 0;
    while ((n_acc < 8 || m_valid) && iters < 300) begin
      a4_cycle((n_acc < 8) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      iters++;
    end
    chk("bp_within_budget", iters < 300, 1'b1);
    chk("bp_delivered", dut_out, 8);

    // continuous streaming, newblock 1,0,0,1
    dut_out = 0;
    a4_cycle(1, 1, 1);
    a4_cycle(1, 0, 1);
    a4_cycle(1, 0, 1);
    a4_cycle(1, 1, 1);
    a4_cycle(0, 0, 1);
    chk("stream_delivered", dut_out, 4);

    // reset while holding a stalled beat; the beat offered during reset is dropped
    a4_cycle(1, 0, 0);
    a4_cycle(1, 1, 0);
    u4.valid = 1; u4.newblock = 1; u4.state = cur_st; u4.w = cur_w; d4.ready = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; u4.valid = 0;
    chk("rst_hold_valid", d4.valid, 1'b0);
    chk("rst_hold_newblock", d4.newblock, 1'b0);
    chk("rst_hold_ready", u4.ready, 1'b1);
    chk("rst_hold_state", d4.state, '0);
    m_valid = 0; m_nb = 0; m_st = '0; m_w = '0;
    a4_cycle(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
